reaction_trial_ctrl: RTL and testbench
======================================

REACTION_TRIAL_CTRL -- requirements
Module: reaction_trial_ctrl

Interface
REQ-001 SHALL provide the following parameters:
- NUM_TRIALS, default 4: successful trials per session; power of 2, >=2.
- TIME_W, default 10: width of ms time fields.
- TIMEOUT_MS, default 1000: reaction window before a late fault; must be < 2^TIME_W.
- PENALTY_MS, default 5000: fault hold time.
- MIN_DELAY_MS, default 500: floor on the random wait.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle debounced pulse; begin or restart session.
- enter  in  1  one-cycle debounced pulse; player response.
- ms_tick  in  1  one-cycle pulse every 1 ms.
- rand_delay  in  TIME_W  pseudo-random wait in ms, sampled on RWAIT entry.
- color_r, color_g, color_b  out  3 each  RGB intensity, 0-7.
- rt_ms  out  TIME_W  last successful reaction time.
- rt_valid  out  1  one-cycle pulse when rt_ms updates.
- best_ms  out  TIME_W  minimum reaction time this session.
- avg_ms  out  TIME_W  session average; valid when done=1.
- trial_idx  out  $clog2(NUM_TRIALS)  current trial number.
- fault_cnt  out  8  early plus late faults this session, saturating at 255.
- done  out  1  high in SUMMARY.

Function
REQ-003 SHALL implement states IDLE, RWAIT, WHITE, RECORD, RED, YELLOW and SUMMARY; every output is registered or decoded from registered state only.
REQ-004 SHALL drive color (r,g,b) per state: IDLE (0,2,0); RWAIT (0,0,0); WHITE and RECORD (4,2,3); RED (7,0,0); YELLOW (7,2,0); SUMMARY (0,0,4).
REQ-005 SHALL, in IDLE or SUMMARY on start: clear trial_idx, fault_cnt and the sum; set best_ms to all-ones; go to RWAIT.
REQ-006 SHALL ignore start in RWAIT, WHITE, RECORD, RED and YELLOW.
REQ-007 SHALL, on RWAIT entry, load the wait counter with max(rand_delay, MIN_DELAY_MS).
REQ-008 SHALL, in RWAIT, decrement the wait counter on ms_tick.
REQ-009 SHALL, in RWAIT, go to WHITE in the cycle after the counter reaches 0.
REQ-010 SHALL, in RWAIT, go to RED on enter while the counter is nonzero.
REQ-011 SHALL, in RWAIT, give priority to enter when enter coincides with the tick that zeroes the counter (early fault).
REQ-012 SHALL, on WHITE entry, clear the reaction counter.
REQ-013 SHALL, in WHITE, increment the reaction counter on ms_tick.
REQ-014 SHALL, in WHITE, go to RECORD on enter, capturing the counter value, including a value of 0.
REQ-015 SHALL, in WHITE, go to YELLOW when the counter equals TIMEOUT_MS and enter is low.
REQ-016 SHALL, in WHITE, give priority to enter when enter and the timeout condition occur in the same cycle.
REQ-017 SHALL, in RECORD (exactly 1 cycle):
- set rt_ms to the captured value and pulse rt_valid;
- set best_ms to min(best_ms, rt_ms);
- add the captured value to the sum (width TIME_W+$clog2(NUM_TRIALS), no overflow possible).
REQ-018 SHALL, in RECORD, go to SUMMARY if trial_idx = NUM_TRIALS-1; otherwise increment trial_idx and go to RWAIT.
REQ-019 SHALL, on entry to RED or YELLOW, increment fault_cnt, saturating at 255, and load the hold counter with PENALTY_MS.
REQ-020 SHALL, in RED or YELLOW, decrement the hold counter on ms_tick and return to RWAIT (same trial_idx, retry) when it reaches 0.
REQ-021 SHALL, in RED or YELLOW, ignore enter and start.
REQ-022 SHALL, in SUMMARY, hold avg_ms = sum >> $clog2(NUM_TRIALS) (truncating).
REQ-023 SHALL, in SUMMARY, keep done=1 and hold all statistics until start.
REQ-024 SHALL ignore ms_tick in IDLE, RECORD and SUMMARY.

Reset
REQ-025 SHALL, on rst high at a clock edge, in any state including mid-trial or mid-penalty, reset to:
- state IDLE, color (0,2,0);
- rt_ms, avg_ms, trial_idx, fault_cnt, all counters and the sum = 0;
- best_ms all-ones;
- rt_valid = 0, done = 0.
REQ-026 SHALL give rst priority over every other input.

Verification
REQ-027 Normal session (defaults): start; rand_delay=700; enter 250, 310, 190, 450 ticks after WHITE in the four trials -> four rt_valid pulses; best_ms=190; avg_ms=300; done=1; fault_cnt=0.
REQ-028 Early press: enter 100 ticks into RWAIT -> RED (7,0,0); fault_cnt=1; after 5000 ticks back to RWAIT with trial_idx unchanged.
REQ-029 Late: no enter in WHITE -> YELLOW on the cycle the counter equals 1000; fault_cnt increments; after the 5000-tick penalty, retry of the same trial.
REQ-030 Delay floor: rand_delay=0 and rand_delay=499 -> WHITE after exactly 500 ticks; rand_delay=800 -> after 800 ticks.
REQ-031 Simultaneous events:
- enter with the tick that zeroes the wait counter -> RED;
- enter in the cycle the reaction counter equals 1000 -> RECORD with rt_ms=1000.
REQ-032 Reset and restart:
- rst asserted in WHITE at 400 ms -> next cycle IDLE with all outputs at reset values;
- start in SUMMARY -> statistics cleared and RWAIT entered.

Source files
------------

// File: rtl/reaction_trial_ctrl.sv
// Reaction-time trial controller.
// A session runs NUM_TRIALS successful trials. Each trial waits a random
// delay (never below MIN_DELAY_MS) with the light dark, then turns the light
// white and times the player's press in ms. An early press (red) or no press
// within TIMEOUT_MS (yellow) costs a PENALTY_MS hold, and the same trial is
// then retried. After the last trial the controller shows the summary.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, enter        one-cycle debounced button pulses
//   ms_tick             one-cycle pulse every millisecond
//   rand_delay          random wait in ms, sampled when a wait begins
//   color_r/g/b         RGB light intensity, 0-7
//   rt_ms, rt_valid     last reaction time and its one-cycle update strobe
//   best_ms, avg_ms     session minimum and average (average valid with done)
//   trial_idx           current trial number
//   fault_cnt           early plus late faults this session, saturating
//   done                high while the session summary is shown
module reaction_trial_ctrl #(
  parameter int unsigned NUM_TRIALS   = 4,
  parameter int unsigned TIME_W       = 10,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned PENALTY_MS   = 5000,
  parameter int unsigned MIN_DELAY_MS = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          enter,
  input  logic                          ms_tick,
  input  logic [TIME_W-1:0]             rand_delay,
  output logic [2:0]                    color_r,
  output logic [2:0]                    color_g,
  output logic [2:0]                    color_b,
  output logic [TIME_W-1:0]             rt_ms,
  output logic                          rt_valid,
  output logic [TIME_W-1:0]             best_ms,
  output logic [TIME_W-1:0]             avg_ms,
  output logic [$clog2(NUM_TRIALS)-1:0] trial_idx,
  output logic [7:0]                    fault_cnt,
  output logic                          done
);

  localparam int unsigned IDX_W  = $clog2(NUM_TRIALS);
  localparam int unsigned SUM_W  = TIME_W + IDX_W;
  // The penalty hold is wider than the ms time fields.
  localparam int unsigned HOLD_W = $clog2(PENALTY_MS + 1);

  localparam logic [TIME_W-1:0] MIN_DELAY = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] TIMEOUT   = TIME_W'(TIMEOUT_MS);
  localparam logic [HOLD_W-1:0] PENALTY   = HOLD_W'(PENALTY_MS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TRIALS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_WHITE,
    S_RECORD,
    S_RED,
    S_YELLOW,
    S_SUMMARY
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TIME_W-1:0]   wait_cnt;
  logic [TIME_W-1:0]   react_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TIME_W-1:0]   cap;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_nxt;
  logic [TIME_W-1:0]   wait_load;

  // Light colour {r,g,b} shown in each state.
  function automatic logic [8:0] color_of(input state_t s);
    case (s)
      S_IDLE:            return {3'd0, 3'd2, 3'd0};
      S_RWAIT:           return {3'd0, 3'd0, 3'd0};
      S_WHITE, S_RECORD: return {3'd4, 3'd2, 3'd3};
      S_RED:             return {3'd7, 3'd0, 3'd0};
      S_YELLOW:          return {3'd7, 3'd2, 3'd0};
      S_SUMMARY:         return {3'd0, 3'd0, 3'd4};
      default:           return {3'd0, 3'd0, 3'd0};
    endcase
  endfunction

  assign wait_load = (rand_delay < MIN_DELAY) ? MIN_DELAY : rand_delay;
  assign sum_nxt   = sum + SUM_W'(cap);

  // Next-state decode; priorities give enter precedence over the
  // simultaneous wait-expiry tick and over the reaction timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_SUMMARY: begin
        if (start) state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (enter && wait_cnt != '0) state_nxt = S_RED;
        else if (wait_cnt == '0)     state_nxt = S_WHITE;
      end
      S_WHITE: begin
        if (enter)                   state_nxt = S_RECORD;
        else if (react_cnt == TIMEOUT) state_nxt = S_YELLOW;
      end
      S_RECORD: begin
        state_nxt = (trial_idx == LAST_IDX) ? S_SUMMARY : S_RWAIT;
      end
      S_RED, S_YELLOW: begin
        // Leave on the tick that would take the hold to zero.
        if (ms_tick && hold_cnt <= HOLD_W'(1)) state_nxt = S_RWAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      {color_r, color_g, color_b} <= color_of(S_IDLE);
      rt_ms     <= '0;
      rt_valid  <= 1'b0;
      best_ms   <= '1;
      avg_ms    <= '0;
      trial_idx <= '0;
      fault_cnt <= '0;
      done      <= 1'b0;
      wait_cnt  <= '0;
      react_cnt <= '0;
      hold_cnt  <= '0;
      cap       <= '0;
      sum       <= '0;
    end else begin
      state    <= state_nxt;
      {color_r, color_g, color_b} <= color_of(state_nxt);
      done     <= (state_nxt == S_SUMMARY);
      rt_valid <= 1'b0;

      // Random wait: load on entry, count down on ticks.
      if (state_nxt == S_RWAIT && state != S_RWAIT) begin
        wait_cnt <= wait_load;
      end else if (state == S_RWAIT && ms_tick && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - TIME_W'(1);
      end

      // Reaction timer: cleared on entry, stops at the timeout value.
      if (state_nxt == S_WHITE && state != S_WHITE) begin
        react_cnt <= '0;
      end else if (state == S_WHITE && ms_tick && react_cnt != TIMEOUT) begin
        react_cnt <= react_cnt + TIME_W'(1);
      end

      if (state == S_WHITE && enter) cap <= react_cnt;

      // Fault entry counts once and arms the penalty hold.
      if ((state_nxt == S_RED || state_nxt == S_YELLOW) && state_nxt != state) begin
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
        hold_cnt <= PENALTY;
      end else if ((state == S_RED || state == S_YELLOW) && ms_tick && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      // New session clears the per-session statistics.
      if ((state == S_IDLE || state == S_SUMMARY) && start) begin
        trial_idx <= '0;
        fault_cnt <= '0;
        sum       <= '0;
        best_ms   <= '1;
      end

      if (state == S_RECORD) begin
        rt_ms    <= cap;
        rt_valid <= 1'b1;
        if (cap < best_ms) best_ms <= cap;
        sum      <= sum_nxt;
        if (trial_idx == LAST_IDX) begin
          avg_ms <= TIME_W'(sum_nxt >> IDX_W);
        end else begin
          trial_idx <= trial_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reaction_trial_ctrl.sv
// Self-checking bench for reaction_trial_ctrl: a phase-level model of a
// session is advanced every clock and all outputs are compared each cycle.
module tb_reaction_trial_ctrl;

  localparam int N       = 4;
  localparam int TW      = 10;
  localparam int TIMEOUT = 1000;
  localparam int PENALTY = 5000;
  localparam int MIN_DLY = 500;
  localparam int ONES    = (1 << TW) - 1;

  localparam int P_IDLE = 0, P_WAIT = 1, P_WHITE = 2, P_REC = 3,
                 P_RED = 4, P_YEL = 5, P_SUM = 6;
  localparam int MD_REACT = 0, MD_EARLY = 1, MD_ZERO = 2, MD_LATE = 3,
                 MD_PEN = 4, MD_WHITE_AT = 5;

  logic          clk = 1'b0;
  logic          rst, start, enter, ms_tick;
  logic [TW-1:0] rand_delay;
  logic [2:0]    color_r, color_g, color_b;
  logic [TW-1:0] rt_ms, best_ms, avg_ms;
  logic          rt_valid, done;
  logic [1:0]    trial_idx;
  logic [7:0]    fault_cnt;

  always #5 clk = ~clk;

  reaction_trial_ctrl #(
    .NUM_TRIALS(N), .TIME_W(TW), .TIMEOUT_MS(TIMEOUT),
    .PENALTY_MS(PENALTY), .MIN_DELAY_MS(MIN_DLY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .enter(enter), .ms_tick(ms_tick),
    .rand_delay(rand_delay), .color_r(color_r), .color_g(color_g),
    .color_b(color_b), .rt_ms(rt_ms), .rt_valid(rt_valid), .best_ms(best_ms),
    .avg_ms(avg_ms), .trial_idx(trial_idx), .fault_cnt(fault_cnt), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Model of the session
  int m_phase = P_IDLE;
  int m_wait, m_elapsed, m_hold, m_cap, m_loaded;
  int m_rts[$];
  int m_faults, m_last_rt, m_avg;
  bit m_rv;
  int exp_r[7] = '{0, 0, 4, 4, 7, 7, 0};
  int exp_g[7] = '{2, 0, 2, 2, 0, 2, 0};
  int exp_b[7] = '{0, 0, 3, 3, 0, 0, 4};

  // Stimulus / measurement state
  logic [TW-1:0] rd_drv;
  int gap_left = 0;
  int wait_ticks, black_ticks, pen_ticks, meas_delay, meas_pen, rv_seen;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      if (errors >= 40) finish_sim();
    end
  endtask

  function automatic int model_best();
    int b = ONES;
    foreach (m_rts[i]) if (m_rts[i] < b) b = m_rts[i];
    return b;
  endfunction

  function automatic int model_trial();
    return (m_rts.size() > N - 1) ? N - 1 : m_rts.size();
  endfunction

  task automatic enter_wait(input int rd);
    m_phase    = P_WAIT;
    m_wait     = (rd < MIN_DLY) ? MIN_DLY : rd;
    m_loaded   = m_wait;
    wait_ticks = 0;
  endtask

  task automatic start_penalty(input int p);
    m_faults = (m_faults < 255) ? m_faults + 1 : 255;
    m_hold   = PENALTY;
    m_phase  = p;
  endtask

  // One clock edge of the session rules, given the inputs applied.
  task automatic model_edge(input bit r, input bit s, input bit e, input bit t, input int rd);
    int total;
    m_rv = 1'b0;
    if (r) begin
      m_phase = P_IDLE; m_rts.delete(); m_faults = 0;
      m_last_rt = 0; m_avg = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_SUM: if (s) begin m_rts.delete(); m_faults = 0; enter_wait(rd); end
        P_WAIT: begin
          if (e && m_wait > 0)  start_penalty(P_RED);
          else if (m_wait == 0) begin m_phase = P_WHITE; m_elapsed = 0; end
          else if (t)           m_wait--;
        end
        P_WHITE: begin
          if (e) begin m_cap = m_elapsed; m_phase = P_REC; end
          else if (m_elapsed == TIMEOUT) start_penalty(P_YEL);
          else if (t) m_elapsed++;
        end
        P_REC: begin
          m_rts.push_back(m_cap);
          m_last_rt = m_cap;
          m_rv = 1'b1;
          if (m_rts.size() == N) begin
            total = 0;
            foreach (m_rts[i]) total += m_rts[i];
            m_avg   = total / N;
            m_phase = P_SUM;
          end else begin
            enter_wait(rd);
          end
        end
        P_RED, P_YEL: if (t) begin
          m_hold--;
          if (m_hold == 0) enter_wait(rd);
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("color_r",   int'(color_r),   exp_r[m_phase]);
    chk("color_g",   int'(color_g),   exp_g[m_phase]);
    chk("color_b",   int'(color_b),   exp_b[m_phase]);
    chk("rt_valid",  int'(rt_valid),  int'(m_rv));
    chk("rt_ms",     int'(rt_ms),     m_last_rt);
    chk("best_ms",   int'(best_ms),   model_best());
    chk("avg_ms",    int'(avg_ms),    m_avg);
    chk("trial_idx", int'(trial_idx), model_trial());
    chk("fault_cnt", int'(fault_cnt), m_faults);
    chk("done",      int'(done),      (m_phase == P_SUM) ? 1 : 0);
  endtask

  // Apply one cycle of inputs, advance the model, check 1 time unit later.
  task automatic step(input bit r, input bit s, input bit e, input bit t);
    bit pre_black, pre_pen;
    rst = r; start = s; enter = e; ms_tick = t; rand_delay = rd_drv;
    pre_black = (color_r == 3'd0 && color_g == 3'd0 && color_b == 3'd0);
    pre_pen   = (color_r == 3'd7);
    if (!pre_black) black_ticks = 0; else if (t) black_ticks++;
    if (!pre_pen)   pen_ticks = 0;   else if (t) pen_ticks++;
    if (m_phase == P_WAIT && t) wait_ticks++;
    @(posedge clk);
    model_edge(r, s, e, t, int'(rd_drv));
    #1;
    compare_all();
    if (rt_valid === 1'b1) rv_seen++;
    if (!r && pre_black && color_r == 3'd4) begin
      meas_delay = black_ticks;
      chk("rwait_ticks", black_ticks, m_loaded);
    end
    if (!r && pre_pen && color_r == 3'd0 && color_g == 3'd0 && color_b == 3'd0) begin
      meas_pen = pen_ticks;
      chk("penalty_ticks", pen_ticks, PENALTY);
    end
  endtask

  // Ticks never fall on consecutive cycles; noise presses where ignored.
  task automatic drive(input bit e, input bit e_on_tick, input bit s);
    bit t, sx, ex;
    if (gap_left == 0) begin
      t = 1'b1;
      gap_left = ($urandom_range(0, 3) == 0) ? 2 : 1;
    end else begin
      t = 1'b0;
      gap_left--;
    end
    sx = s;
    ex = e | (e_on_tick & t);
    if (m_phase != P_IDLE && m_phase != P_SUM && $urandom_range(0, 63) == 0) sx = 1'b1;
    if ((m_phase == P_RED || m_phase == P_YEL) && $urandom_range(0, 31) == 0) ex = 1'b1;
    step(1'b0, sx, ex, t);
  endtask

  task automatic run_trial(input int mode, input int param, input string tag);
    bit reached = 1'b0;
    for (int c = 0; c < 40000 && !reached; c++) begin
      bit e, eot;
      e = 1'b0; eot = 1'b0;
      case (mode)
        MD_REACT: e   = (m_phase == P_WHITE && m_elapsed == param);
        MD_EARLY: e   = (m_phase == P_WAIT && wait_ticks == param);
        MD_ZERO:  eot = (m_phase == P_WAIT && m_wait == 1);
        default: ;
      endcase
      drive(e, eot, 1'b0);
      case (mode)
        MD_REACT:         reached = m_rv;
        MD_EARLY, MD_ZERO: reached = (m_phase == P_RED);
        MD_LATE:          reached = (m_phase == P_YEL);
        MD_PEN:           reached = (m_phase == P_WAIT);
        MD_WHITE_AT:      reached = (m_phase == P_WHITE && m_elapsed == param);
        default:          reached = 1'b1;
      endcase
    end
    chk({"reached_", tag}, int'(reached), 1);
  endtask

  initial begin
    #3_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    finish_sim();
  end

  initial begin
    int rsum, rmin, rv;
    rst = 1'b1; start = 1'b0; enter = 1'b0; ms_tick = 1'b0;
    rd_drv = 10'd700; rand_delay = 10'd700;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_color_g", int'(color_g), 2);
    chk("reset_best", int'(best_ms), 1023);
    chk("reset_done", int'(done), 0);

    // Normal session: 700 ms waits, reactions 250/310/190/450.
    rv_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_color", int'({color_r, color_g, color_b}), 0);
    run_trial(MD_REACT, 250, "n0");
    chk("delay_700", meas_delay, 700);
    run_trial(MD_REACT, 310, "n1");
    run_trial(MD_REACT, 190, "n2");
    run_trial(MD_REACT, 450, "n3");
    chk("normal_rv_pulses", rv_seen, 4);
    chk("normal_best", int'(best_ms), 190);
    chk("normal_avg", int'(avg_ms), 300);
    chk("normal_done", int'(done), 1);
    chk("normal_faults", int'(fault_cnt), 0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    chk("summary_hold_avg", int'(avg_ms), 300);

    // Restart from summary, then delay floor.
    rd_drv = 10'd0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_done", int'(done), 0);
    chk("restart_trial", int'(trial_idx), 0);
    chk("restart_best", int'(best_ms), 1023);
    rd_drv = 10'd499;
    run_trial(MD_REACT, 5, "f0");
    chk("floor_rd0", meas_delay, 500);
    rd_drv = 10'd800;
    run_trial(MD_REACT, 7, "f1");
    chk("floor_rd499", meas_delay, 500);
    rd_drv = 10'd600;
    run_trial(MD_REACT, 9, "f2");
    chk("delay_800", meas_delay, 800);

    // Early press, enter on the zeroing tick, late fault.
    rd_drv = 10'd650;
    run_trial(MD_EARLY, 100, "early");
    chk("early_color", int'({color_r, color_g, color_b}), 9'o700);
    chk("early_faults", int'(fault_cnt), 1);
    chk("early_trial", int'(trial_idx), 3);
    run_trial(MD_PEN, 0, "pen1");
    chk("pen1_ticks", meas_pen, 5000);
    chk("pen1_trial", int'(trial_idx), 3);
    run_trial(MD_ZERO, 0, "zero");
    chk("zero_red", int'(color_r), 7);
    chk("zero_faults", int'(fault_cnt), 2);
    run_trial(MD_PEN, 0, "pen2");
    run_trial(MD_LATE, 0, "late");
    chk("late_color", int'({color_r, color_g, color_b}), 9'o720);
    chk("late_faults", int'(fault_cnt), 3);
    run_trial(MD_PEN, 0, "pen3");
    chk("pen3_trial", int'(trial_idx), 3);
    run_trial(MD_REACT, 1000, "at_timeout");
    chk("timeout_rt", int'(rt_ms), 1000);
    chk("timeout_avg", int'(avg_ms), 255);
    chk("timeout_best", int'(best_ms), 5);

    // Reset in WHITE at 400 ms.
    rd_drv = 10'd500;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_trial(MD_WHITE_AT, 400, "white400");
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_color", int'({color_r, color_g, color_b}), 9'o020);
    chk("rst_rt", int'(rt_ms), 0);
    chk("rst_avg", int'(avg_ms), 0);
    chk("rst_best", int'(best_ms), 1023);
    chk("rst_faults", int'(fault_cnt), 0);

    // Randomized session; first reaction is 0 ms.
    rv_seen = 0; rsum = 0; rmin = ONES;
    rd_drv = TW'($urandom_range(0, 900));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      rv = (i == 0) ? 0 : int'($urandom_range(0, 999));
      rsum += rv;
      if (rv < rmin) rmin = rv;
      rd_drv = TW'($urandom_range(0, 900));
      run_trial(MD_REACT, rv, "rand");
    end
    chk("rand_rv_pulses", rv_seen, 4);
    chk("rand_avg", int'(avg_ms), rsum / 4);
    chk("rand_best", int'(best_ms), rmin);
    chk("rand_done", int'(done), 1);

    finish_sim();
  end

endmodule
